// File: rtl/multi_pkg.sv
// multi_pkg
// Shared definitions for the parametrised shift-add multiplier:
//   state_e  - FSM state encoding (IDLE, CALC, DONE)
//   NEG_W    - widest product the negate helper covers (products up to 256 bits,
//              i.e. operands up to 128 bits)
//   negate2c - two's-complement negate, truncated by the caller to its own width
package multi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NEG_W = 256;

  // Negation modulo 2^NEG_W; its low bits equal the negation at any narrower
  // width, so callers cast the result down to their product width.
  function automatic logic [NEG_W-1:0] negate2c(input logic [NEG_W-1:0] value);
    return ~value + NEG_W'(1);
  endfunction

endpackage

// File: rtl/multi_sgnmag.sv
// multi_sgnmag
// Combinational conversion of a WIDTH-bit operand into sign and magnitude.
// Ports:
//   signed_mode_i - 1: operand is two's complement, 0: operand is unsigned
//   operand_i     - raw operand
//   sign_o        - 1 when the operand is negative (signed mode only)
//   magnitude_o   - absolute value as an unsigned WIDTH-bit number
module multi_sgnmag #(
  parameter int WIDTH = 32
) (
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic             sign_o,
  output logic [WIDTH-1:0] magnitude_o
);

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  always_comb begin
    sign_o      = signed_mode_i & operand_i[WIDTH-1];
    magnitude_o = sign_o ? (~operand_i + WIDTH'(1)) : operand_i;
  end

endmodule

// File: rtl/multi_param.sv
// multi_param
// Sequential shift-add multiplier, one multiplier bit per cycle, with optional
// early termination, signed/unsigned operands, busy flag and abort.
// Ports:
//   clock       - rising-edge clock
//   reset_n     - asynchronous active-low reset
//   start       - request, accepted only while idle and not busy
//   signed_mode - operand interpretation, captured with start
//   abort       - cancels an operation while it is calculating
//   mlier/mcand - multiplier and multiplicand, captured with start
//   product     - 2*WIDTH-bit result, held until the next valid
//   valid       - one-cycle pulse when product is updated
//   busy        - high from the cycle after start through the valid cycle
module multi_param
  import multi_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               abort,
  input  logic [WIDTH-1:0]   mlier,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] product,
  output logic               valid,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_e          state_q;
  logic [WIDTH-1:0] rem_q;
  logic [PW-1:0]   mcandSh_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   count_q;
  logic            neg_q;
  logic [PW-1:0]   product_q;
  logic            valid_q;
  logic            busy_q;

  logic             mlierSign;
  logic             mcandSign;
  logic [WIDTH-1:0] mlierMag;
  logic [WIDTH-1:0] mcandMag;

  logic [WIDTH-1:0] rem_d;
  logic [PW-1:0]    mcandSh_d;
  logic [PW-1:0]    acc_d;
  logic [CW-1:0]    count_d;
  logic [PW-1:0]    result_d;
  logic             calcDone;

  multi_sgnmag #(.WIDTH(WIDTH)) uMlierSgnMag (
    .signed_mode_i (signed_mode),
    .operand_i     (mlier),
    .sign_o        (mlierSign),
    .magnitude_o   (mlierMag)
  );

  multi_sgnmag #(.WIDTH(WIDTH)) uMcandSgnMag (
    .signed_mode_i (signed_mode),
    .operand_i     (mcand),
    .sign_o        (mcandSign),
    .magnitude_o   (mcandMag)
  );

  // One shift-add step of the datapath plus the termination test. Early
  // termination looks at the already-shifted multiplier so the step that
  // consumes the last set bit is also the last CALC cycle; a zero
  // multiplicand can never add anything, so it also ends the operation.
  always_comb begin
    acc_d     = rem_q[0] ? (acc_q + mcandSh_q) : acc_q;
    rem_d     = rem_q >> 1;
    mcandSh_d = mcandSh_q << 1;
    count_d   = count_q + CW'(1);
    calcDone  = (count_d == CW'(WIDTH));
    if (EARLY_TERM) begin
      calcDone = calcDone | (rem_d == '0) | (mcandSh_q == '0);
    end
    // A zero result keeps its zero encoding even when the sign is negative.
    result_d = (neg_q && (acc_q != '0)) ? PW'(negate2c(NEG_W'(acc_q))) : acc_q;
  end

  // FSM with registered outputs. busy_q stays high through the valid cycle
  // (which the FSM already spends in IDLE) and that cycle refuses start,
  // leaving one non-busy cycle before the next operation can be accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      mcandSh_q <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (!busy_q && start && !abort) begin
            rem_q     <= mlierMag;
            mcandSh_q <= PW'(mcandMag);
            acc_q     <= '0;
            count_q   <= '0;
            neg_q     <= mlierSign ^ mcandSign;
            busy_q    <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            mcandSh_q <= mcandSh_d;
            count_q   <= count_d;
            if (calcDone) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          product_q <= result_d;
          valid_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign product = product_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule
